// File: rtl/serial_sub_pkg_a34.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_sub_pkg_a34;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Counter must hold 0..SIZE so that SIZE-1 is always representable.
   function automatic int cnt_width(input int size);
      return $clog2(size + 1);
   endfunction

endpackage

// File: rtl/full_subtractor_cell_a34.sv
// One-bit full subtractor: d = x - y - bin, bout set when the bit borrows.
module full_subtractor_cell_a34 (
   input  logic x_i,
   input  logic y_i,
   input  logic bin_i,
   output logic d_o,
   output logic bout_o
);

   assign d_o    = x_i ^ y_i ^ bin_i;
   assign bout_o = (~x_i & y_i) | (~(x_i ^ y_i) & bin_i);

endmodule

// File: rtl/serial_subtractor_a34.sv
// Bit-serial subtractor: diff = a - b - b_in, LSB first, one bit per clock,
// with valid/ready handshakes on both the operand and result sides.
module serial_subtractor_a34
   import serial_sub_pkg_a34::*;
#(
   parameter int SIZE = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [SIZE-1:0] a,
   input  logic [SIZE-1:0] b,
   input  logic            b_in,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [SIZE-1:0] diff,
   output logic            b_out,
   output logic            busy
);

   localparam int CW = cnt_width(SIZE);

   state_e          state_q, state_d;
   logic [SIZE-1:0] a_sh_q, a_sh_d;
   logic [SIZE-1:0] b_sh_q, b_sh_d;
   logic [SIZE-1:0] res_q, res_d;
   logic [SIZE-1:0] diff_q, diff_d;
   logic            borrow_q, borrow_d;
   logic            b_out_q, b_out_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   logic            cell_d_s;
   logic            cell_bo_s;
   logic [SIZE:0]   res_cat_s;
   logic [SIZE-1:0] res_shift_s;

   full_subtractor_cell_a34 u_cell (
      .x_i    (a_sh_q[0]),
      .y_i    (b_sh_q[0]),
      .bin_i  (borrow_q),
      .d_o    (cell_d_s),
      .bout_o (cell_bo_s)
   );

   // New bit enters at the MSB; the concatenation keeps SIZE=1 legal.
   assign res_cat_s   = {cell_d_s, res_q};
   assign res_shift_s = res_cat_s[SIZE:1];

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q == RUN);
   assign out_valid = (state_q == DONE);
   assign diff      = diff_q;
   assign b_out     = b_out_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         res_q    <= '0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         b_out_q  <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         res_q    <= res_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
         b_out_q  <= b_out_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      res_d    = res_q;
      diff_d   = diff_q;
      borrow_d = borrow_q;
      b_out_d  = b_out_q;
      cnt_d    = cnt_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_sh_d   = a;
               b_sh_d   = b;
               borrow_d = b_in;
               cnt_d    = '0;
               state_d  = RUN;
            end else begin
               state_d  = IDLE;
            end
         end
         RUN: begin
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            res_d    = res_shift_s;
            borrow_d = cell_bo_s;
            cnt_d    = cnt_q + CW'(1);
            // Result outputs are published only on the last step so they hold during RUN.
            if (cnt_q == CW'(SIZE - 1)) begin
               diff_d  = res_shift_s;
               b_out_d = cell_bo_s;
               state_d = DONE;
            end else begin
               state_d = RUN;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_serial_subtractor_a34.sv
// Self-checking bench: cycle-level model for SIZE=8 plus directed/random checks for SIZE=1 and 16.
module tb_serial_subtractor_a34;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   logic       iv, ir, ov, ordy, bi, bo, busy;
   logic [7:0] a, b, diff;

   logic       iv1, ir1, ov1, ordy1, bi1, bo1, busy1;
   logic [0:0] a1, b1, diff1;

   logic        iv16, ir16, ov16, ordy16, bi16, bo16, busy16;
   logic [15:0] a16, b16, diff16;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   serial_subtractor_a34 #(.SIZE(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .a(a), .b(b), .b_in(bi),
      .out_valid(ov), .out_ready(ordy), .diff(diff), .b_out(bo), .busy(busy)
   );

   serial_subtractor_a34 #(.SIZE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .b_in(bi1),
      .out_valid(ov1), .out_ready(ordy1), .diff(diff1), .b_out(bo1), .busy(busy1)
   );

   serial_subtractor_a34 #(.SIZE(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .b_in(bi16),
      .out_valid(ov16), .out_ready(ordy16), .diff(diff16), .b_out(bo16), .busy(busy16)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Transaction-level model of the SIZE=8 instance: accept, result after 8 edges, hold until taken.
   logic       m_on  = 1'b0;
   logic       m_act = 1'b0;
   int         m_age = 0;
   logic [7:0] m_exp_d, m_last_d;
   logic       m_exp_b, m_last_b;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rst_n) begin
         m_on     <= 1'b1;
         m_act    <= 1'b0;
         m_age    <= 0;
         m_last_d <= 8'h00;
         m_last_b <= 1'b0;
      end else if (!m_act) begin
         if (iv) begin
            m_act <= 1'b1;
            m_age <= 0;
            {m_exp_b, m_exp_d} <= {1'b0, a} - {1'b0, b} - {8'h00, bi};
         end
      end else if (m_age < 8) begin
         m_age <= m_age + 1;
         if (m_age == 7) begin
            m_last_d <= m_exp_d;
            m_last_b <= m_exp_b;
         end
      end else if (ordy) begin
         m_act <= 1'b0;
      end
   end

   always @(negedge clk) begin
      if (m_on) begin
         chk("in_ready", 32'(ir), 32'(!m_act));
         chk("busy", 32'(busy), 32'(m_act && m_age < 8));
         chk("out_valid", 32'(ov), 32'(m_act && m_age == 8));
         chk("diff", 32'(diff), 32'(m_last_d));
         chk("b_out", 32'(bo), 32'(m_last_b));
      end
   end

   task automatic txn8(input logic [7:0] ta, input logic [7:0] tb, input logic tbi,
                       input logic [7:0] ed, input logic eb, input bit hold);
      int n;
      @(negedge clk);
      a = ta; b = tb; bi = tbi; iv = 1'b1; ordy = 1'b0;
      @(negedge clk);
      if (hold) begin
         a = 8'h00; b = 8'hFF;
      end else begin
         iv = 1'b0;
      end
      n = 0;
      while (!ov && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("latency8", 32'(n), 32'd8);
      chk("diff_lit", 32'(diff), 32'(ed));
      chk("b_out_lit", 32'(bo), 32'(eb));
      if (hold) begin
         repeat (5) begin
            @(negedge clk);
            chk("hold_diff", 32'(diff), 32'(ed));
            chk("hold_b_out", 32'(bo), 32'(eb));
            chk("hold_in_ready", 32'(ir), 32'd0);
         end
      end
      ordy = 1'b1;
      @(negedge clk);
      iv = 1'b0; ordy = 1'b0;
      chk("post_handshake_ov", 32'(ov), 32'd0);
   endtask

   task automatic sweep1();
      int n;
      logic [1:0] r;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         a1 = 1'($urandom); b1 = 1'($urandom); bi1 = 1'($urandom); iv1 = 1'b1; ordy1 = 1'b1;
         r = {1'b0, a1} - {1'b0, b1} - {1'b0, bi1};
         @(negedge clk);
         iv1 = 1'b0;
         n = 0;
         while (!ov1 && n < 40) begin
            @(negedge clk);
            n++;
         end
         chk("s1_latency", 32'(n), 32'd1);
         chk("s1_diff", 32'(diff1), 32'(r[0]));
         chk("s1_b_out", 32'(bo1), 32'(r[1]));
      end
      @(negedge clk);
      ordy1 = 1'b0;
   endtask

   task automatic sweep16();
      int n;
      logic [16:0] r;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         a16 = 16'($urandom); b16 = 16'($urandom); bi16 = 1'($urandom);
         if (i == 0) begin a16 = 16'h0000; b16 = 16'hFFFF; bi16 = 1'b1; end
         if (i == 1) begin a16 = 16'hFFFF; b16 = 16'h0000; bi16 = 1'b0; end
         iv16 = 1'b1; ordy16 = 1'b1;
         r = {1'b0, a16} - {1'b0, b16} - {16'h0000, bi16};
         @(negedge clk);
         iv16 = 1'b0;
         n = 0;
         while (!ov16 && n < 40) begin
            @(negedge clk);
            n++;
         end
         chk("s16_latency", 32'(n), 32'd16);
         chk("s16_diff", 32'(diff16), 32'(r[15:0]));
         chk("s16_b_out", 32'(bo16), 32'(r[16]));
      end
      @(negedge clk);
      ordy16 = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int rises[$];
      logic prev_ov;
      rst_n = 1'b0;
      iv = 1'b0; ordy = 1'b0; a = 8'h00; b = 8'h00; bi = 1'b0;
      iv1 = 1'b0; ordy1 = 1'b0; a1 = 1'b0; b1 = 1'b0; bi1 = 1'b0;
      iv16 = 1'b0; ordy16 = 1'b0; a16 = 16'h0000; b16 = 16'h0000; bi16 = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", 32'(ir), 32'd1);
      chk("rst_out_valid", 32'(ov), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_diff", 32'(diff), 32'd0);
      chk("rst_b_out", 32'(bo), 32'd0);
      rst_n = 1'b1;

      txn8(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0);
      txn8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
      txn8(8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0);
      txn8(8'h33, 8'h44, 1'b0, 8'hEF, 1'b1, 1'b1);

      // Abort in the third RUN cycle.
      @(negedge clk);
      a = 8'hAA; b = 8'h55; bi = 1'b0; iv = 1'b1;
      @(negedge clk);
      iv = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("abort_in_ready", 32'(ir), 32'd1);
      chk("abort_out_valid", 32'(ov), 32'd0);
      chk("abort_diff", 32'(diff), 32'd0);
      chk("abort_b_out", 32'(bo), 32'd0);
      txn8(8'hFF, 8'h01, 1'b0, 8'hFE, 1'b0, 1'b0);

      // Back-to-back with out_ready held high.
      @(negedge clk);
      a = 8'h81; b = 8'h7F; bi = 1'b1; iv = 1'b1; ordy = 1'b1;
      prev_ov = 1'b0;
      for (int i = 0; i < 80 && rises.size() < 3; i++) begin
         @(negedge clk);
         if (ov && !prev_ov) rises.push_back(cyc);
         prev_ov = ov;
      end
      iv = 1'b0;
      chk("b2b_count", 32'(rises.size()), 32'd3);
      if (rises.size() == 3) begin
         chk("b2b_gap0", 32'(rises[1] - rises[0]), 32'd10);
         chk("b2b_gap1", 32'(rises[2] - rises[1]), 32'd10);
      end
      chk("b2b_diff", 32'(diff), 32'h01);
      @(negedge clk);
      ordy = 1'b0;
      repeat (2) @(negedge clk);

      sweep1();
      sweep16();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
